// File: rtl/corelet_pkg.sv
// Shared definitions for the corelet sequencer: inst_q field positions, the idle word,
// FSM state encoding and small word-building helpers.
package corelet_pkg;

  localparam int INST_W      = 34;
  localparam int KERNEL_LOAD = 0;
  localparam int EXECUTE     = 1;
  localparam int L0_WR       = 2;
  localparam int L0_RD       = 3;
  localparam int OFIFO_RD    = 6;
  localparam int A_XMEM_LSB  = 7;
  localparam int WEN_XMEM    = 18;
  localparam int CEN_XMEM    = 19;
  localparam int A_PMEM_LSB  = 20;
  localparam int WEN_PMEM    = 31;
  localparam int CEN_PMEM    = 32;
  localparam int ADDR_W      = 11;

  // Both memories deselected (active-low enables high), no strobes.
  localparam logic [INST_W-1:0] IDLE_INST = (34'd1 << WEN_XMEM) | (34'd1 << CEN_XMEM) |
                                            (34'd1 << WEN_PMEM) | (34'd1 << CEN_PMEM);

  typedef enum logic [2:0] {
    IDLE,
    WLOAD,
    KLOAD,
    KGAP,
    ALOAD,
    EXEC,
    DRAIN,
    DONE
  } state_t;

  function automatic logic [ADDR_W-1:0] addr_add(input logic [ADDR_W-1:0] base,
                                                 input logic [8:0]        off);
    return base + {2'b00, off};
  endfunction

  function automatic logic [INST_W-1:0] xmem_rd_inst(input logic [ADDR_W-1:0] a);
    logic [INST_W-1:0] w;
    w = IDLE_INST;
    w[CEN_XMEM] = 1'b0;
    w[A_XMEM_LSB +: ADDR_W] = a;
    return w;
  endfunction

  function automatic logic [INST_W-1:0] pmem_wr_inst(input logic [ADDR_W-1:0] a);
    logic [INST_W-1:0] w;
    w = IDLE_INST;
    w[CEN_PMEM] = 1'b0;
    w[WEN_PMEM] = 1'b0;
    w[OFIFO_RD] = 1'b1;
    w[A_PMEM_LSB +: ADDR_W] = a;
    return w;
  endfunction

  function automatic logic [INST_W-1:0] l0_rd_inst(input logic kernel);
    logic [INST_W-1:0] w;
    w = IDLE_INST;
    w[L0_RD] = 1'b1;
    if (kernel) w[KERNEL_LOAD] = 1'b1;
    else        w[EXECUTE]     = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/corelet_ctrl_xmem_rd_pipe.sv
// Delays an issued xmem read by one cycle to form the L0 write strobe (xmem read latency).
// Clearing drops the in-flight strobe so an aborted read never lands in L0.
module xmem_rd_pipe (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic rd,
  output logic l0_wr
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) l0_wr <= 1'b0;
    else        l0_wr <= rd & ~clr;
  end

endmodule

// File: rtl/corelet_ctrl.sv
// Tile sequencer: weights xmem->L0->array, then activation chunks xmem->L0->execute->pmem.
// Outputs registered; the word computed each cycle is the one presented during the next.
module corelet_ctrl
  import corelet_pkg::*;
#(
  parameter int                row      = 8,
  parameter int                col      = 8,
  parameter int                L0_DEPTH = 16,
  parameter logic [ADDR_W-1:0] WGT_BASE = 11'd0,
  parameter logic [ADDR_W-1:0] ACT_BASE = 11'd64,
  parameter logic [ADDR_W-1:0] OUT_BASE = 11'd0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        n_act,
  input  logic              abort,
  input  logic              l0_full,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst_q,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [8:0] COL_LAST = 9'(col - 1);
  localparam logic [8:0] GAP_LAST = 9'(row + col - 1);
  localparam logic [8:0] L0_D     = 9'(L0_DEPTH);

  state_t            state, state_nxt;
  logic [8:0]        cnt, cnt_nxt, aptr, aptr_nxt, optr, optr_nxt, chunk, chunk_nxt;
  logic [8:0]        remain, chunk_min;
  logic [7:0]        n_act_q, n_act_nxt;
  logic [INST_W-1:0] inst_r, inst_nxt;
  logic              start_ok, load_chunk, write_ok, l0_wr, err_nxt;

  assign remain    = {1'b0, n_act_q} - aptr;
  assign chunk_min = (remain > L0_D) ? L0_D : remain;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    aptr_nxt   = aptr;
    optr_nxt   = optr;
    chunk_nxt  = chunk;
    n_act_nxt  = n_act_q;
    inst_nxt   = IDLE_INST;
    start_ok   = 1'b0;
    load_chunk = 1'b0;
    write_ok   = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: if (start) begin
          start_ok  = 1'b1;
          n_act_nxt = n_act;
          aptr_nxt  = '0;
          optr_nxt  = '0;
          cnt_nxt   = '0;
          state_nxt = WLOAD;
          inst_nxt  = xmem_rd_inst(WGT_BASE);
        end
        WLOAD: if (cnt == COL_LAST) begin
          state_nxt = KLOAD;
          cnt_nxt   = '0;
          inst_nxt  = l0_rd_inst(1'b1);
        end else begin
          cnt_nxt  = cnt + 9'd1;
          inst_nxt = xmem_rd_inst(addr_add(WGT_BASE, cnt + 9'd1));
        end
        KLOAD: if (cnt == COL_LAST) begin
          state_nxt = KGAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt  = cnt + 9'd1;
          inst_nxt = l0_rd_inst(1'b1);
        end
        KGAP: if (cnt == GAP_LAST) begin
          if (n_act_q == 8'd0) state_nxt = DONE;
          else                 load_chunk = 1'b1;
        end else begin
          cnt_nxt = cnt + 9'd1;
        end
        ALOAD: if (cnt == chunk - 9'd1) begin
          state_nxt = EXEC;
          cnt_nxt   = '0;
          inst_nxt  = l0_rd_inst(1'b0);
        end else begin
          cnt_nxt  = cnt + 9'd1;
          inst_nxt = xmem_rd_inst(addr_add(ACT_BASE, aptr));
          aptr_nxt = aptr + 9'd1;
        end
        EXEC: if (cnt == chunk - 9'd1) begin
          state_nxt = DRAIN;
          cnt_nxt   = '0;
          write_ok  = ofifo_valid;
        end else begin
          cnt_nxt  = cnt + 9'd1;
          inst_nxt = l0_rd_inst(1'b0);
        end
        // cnt counts pmem writes already issued for this chunk
        DRAIN: if (cnt == chunk) begin
          if (aptr < {1'b0, n_act_q}) load_chunk = 1'b1;
          else                        state_nxt  = DONE;
        end else begin
          write_ok = ofifo_valid;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (load_chunk) begin
        state_nxt = ALOAD;
        cnt_nxt   = '0;
        chunk_nxt = chunk_min;
        inst_nxt  = xmem_rd_inst(addr_add(ACT_BASE, aptr));
        aptr_nxt  = aptr + 9'd1;
      end
      if (write_ok) begin
        inst_nxt = pmem_wr_inst(addr_add(OUT_BASE, optr));
        optr_nxt = optr + 9'd1;
        cnt_nxt  = cnt_nxt + 9'd1;
      end
    end
  end

  assign err_nxt = start_ok ? 1'b0 : (err | (l0_wr & l0_full));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      aptr    <= '0;
      optr    <= '0;
      chunk   <= '0;
      n_act_q <= '0;
      inst_r  <= IDLE_INST;
      busy    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      aptr    <= aptr_nxt;
      optr    <= optr_nxt;
      chunk   <= chunk_nxt;
      n_act_q <= n_act_nxt;
      inst_r  <= inst_nxt;
      busy    <= (state_nxt != IDLE);
      done    <= (state_nxt == DONE);
      err     <= err_nxt;
    end
  end

  xmem_rd_pipe u_rd_pipe (
    .clk   (clk),
    .reset (reset),
    .clr   (abort),
    .rd    (~inst_r[CEN_XMEM]),
    .l0_wr (l0_wr)
  );

  always_comb begin
    inst_q        = inst_r;
    inst_q[L0_WR] = l0_wr;
  end

endmodule

// File: tb/tb_corelet_ctrl.sv
// Randomized scoreboard bench for corelet_ctrl: a transaction-level model queues the
// expected non-idle instruction words per tile; a monitor pops and compares each one.
module tb_corelet_ctrl;

  localparam int ROW = 8;
  localparam int COL = 8;
  localparam int L0D = 16;
  localparam int WGT = 0;
  localparam int ACT = 64;
  localparam int OUT = 0;
  localparam logic [33:0] IDLE_W = 34'h1_800C_0000;

  logic        clk = 1'b0;
  logic        reset, start, abort, l0_full, ofifo_valid;
  logic [7:0]  n_act;
  logic [33:0] inst_q;
  logic        busy, done, err;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .n_act(n_act), .abort(abort),
    .l0_full(l0_full), .ofifo_valid(ofifo_valid), .inst_q(inst_q),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          busy_cyc = 0;
  int          done_cnt = 0;
  int          exp_cycles = -1;
  logic        exp_err = 1'b0;
  logic        mon_en  = 1'b0;
  logic        prev_rd = 1'b0;
  logic [34:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [33:0] xrd_w(input int a);
    logic [33:0] w;
    w = IDLE_W;
    w[19] = 1'b0;
    w[17:7] = a[10:0];
    return w;
  endfunction

  function automatic logic [33:0] pwr_w(input int a);
    logic [33:0] w;
    w = IDLE_W;
    w[32] = 1'b0;
    w[31] = 1'b0;
    w[6]  = 1'b1;
    w[30:20] = a[10:0];
    return w;
  endfunction

  function automatic logic [33:0] l0rd_w(input bit kernel);
    logic [33:0] w;
    w = IDLE_W;
    w[3] = 1'b1;
    if (kernel) w[0] = 1'b1;
    else        w[1] = 1'b1;
    return w;
  endfunction

  // Expected tile as a flat list of instruction words (gap/stall cycles are idle, not listed)
  function automatic void build_model(input int n);
    int c;
    exp_q.delete();
    for (int i = 0; i < COL; i++) exp_q.push_back({1'b0, xrd_w(WGT + i)});
    for (int i = 0; i < COL; i++) exp_q.push_back({1'b0, l0rd_w(1'b1)});
    for (int b = 0; b < n; b += L0D) begin
      c = (n - b < L0D) ? n - b : L0D;
      for (int j = 0; j < c; j++) exp_q.push_back({1'b0, xrd_w(ACT + b + j)});
      for (int j = 0; j < c; j++) exp_q.push_back({1'b0, l0rd_w(1'b0)});
      for (int j = 0; j < c; j++) exp_q.push_back({1'b0, pwr_w(OUT + b + j)});
    end
    exp_q.push_back({1'b1, IDLE_W});
  endfunction

  always @(posedge clk) begin
    logic [33:0] w;
    logic [34:0] e;
    #1;
    w = inst_q;
    w[2] = 1'b0;
    if (busy) busy_cyc++;
    else      busy_cyc = 0;
    if (done) done_cnt++;
    if (mon_en) begin
      if (inst_q[2] || prev_rd) check("l0_wr_lag", 64'(inst_q[2]), 64'(prev_rd));
      if (w != IDLE_W || done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'({done, w}), 64'({1'b0, IDLE_W}));
        end else begin
          e = exp_q.pop_front();
          check("inst_word", 64'({done, w}), 64'(e));
        end
        if (!w[32]) check("pmem_wr_needs_valid", 64'(ofifo_valid), 64'(1));
      end
      if (done) begin
        if (exp_cycles >= 0) check("busy_cycles", 64'(busy_cyc), 64'(exp_cycles));
        check("err_at_done", 64'(err), 64'(exp_err));
      end
    end
    prev_rd = !inst_q[19];
  end

  // vmode: 0 valid tied high, 1 random, 2 pattern 1,0,0 repeating
  task automatic run_tile(input int n, input int vmode, input bit full_mode);
    int d0, k;
    build_model(n);
    exp_err    = full_mode;
    exp_cycles = (vmode == 0) ? (COL + COL + (ROW + COL) + 3 * n + 1) : -1;
    d0 = done_cnt;
    k  = 0;
    @(negedge clk);
    ofifo_valid = (vmode == 0);
    start = 1'b1;
    n_act = 8'(n);
    @(negedge clk);
    start = 1'b0;
    n_act = 8'($urandom_range(0, 255));
    while (done_cnt == d0 && k < 3000) begin
      @(negedge clk);
      k++;
      case (vmode)
        0:       ofifo_valid = 1'b1;
        1:       ofifo_valid = 1'($urandom_range(0, 1));
        default: ofifo_valid = (k % 3 == 0);
      endcase
      if (full_mode && !inst_q[19] && inst_q[17:7] >= 11'(ACT)) l0_full = 1'b1;
    end
    if (done_cnt == d0) check("done_timeout", 64'(k), 64'(0));
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    l0_full = 1'b0;
    ofifo_valid = 1'b0;
  endtask

  initial begin
    int d0, k;
    reset = 1'b0; start = 1'b0; abort = 1'b0; l0_full = 1'b0;
    ofifo_valid = 1'b0; n_act = 8'd0;
    #12;
    check("reset_inst", 64'(inst_q), 64'(IDLE_W));
    check("reset_busy", 64'(busy), 64'(0));
    check("reset_done", 64'(done), 64'(0));
    check("reset_err",  64'(err),  64'(0));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    mon_en = 1'b1;

    run_tile(4, 0, 1'b0);
    run_tile(20, 0, 1'b0);
    run_tile(0, 0, 1'b0);
    run_tile(7, 2, 1'b0);
    run_tile(20, 2, 1'b0);
    run_tile(10, 0, 1'b1);
    for (int i = 0; i < 4; i++) run_tile(int'($urandom_range(0, 40)), int'($urandom_range(0, 2)), 1'b0);

    // abort and start together in IDLE: abort wins
    mon_en = 1'b0;
    @(negedge clk);
    start = 1'b1; abort = 1'b1; n_act = 8'd5;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("abort_start_busy", 64'(busy), 64'(0));
    check("abort_start_inst", 64'(inst_q), 64'(IDLE_W));

    // abort mid-EXEC
    ofifo_valid = 1'b1;
    start = 1'b1; n_act = 8'd8;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (!inst_q[1] && k < 500) begin @(negedge clk); k++; end
    check("exec_seen_before_abort", 64'(inst_q[1]), 64'(1));
    abort = 1'b1;
    d0 = done_cnt;
    @(negedge clk);
    abort = 1'b0;
    check("abort_inst", 64'(inst_q), 64'(IDLE_W));
    check("abort_busy", 64'(busy), 64'(0));
    repeat (5) @(negedge clk);
    check("abort_no_done", 64'(done_cnt), 64'(d0));
    mon_en = 1'b1;
    run_tile(2, 0, 1'b0);

    // async reset mid-DRAIN with err set
    mon_en = 1'b0;
    @(negedge clk);
    ofifo_valid = 1'b1; l0_full = 1'b1;
    start = 1'b1; n_act = 8'd20;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (inst_q[32] && k < 500) begin @(negedge clk); k++; end
    check("drain_seen_before_reset", 64'(inst_q[32]), 64'(0));
    check("err_before_reset", 64'(err), 64'(1));
    #2 reset = 1'b0;
    #1;
    check("arst_inst", 64'(inst_q), 64'(IDLE_W));
    check("arst_busy", 64'(busy), 64'(0));
    check("arst_done", 64'(done), 64'(0));
    check("arst_err",  64'(err),  64'(0));
    @(negedge clk);
    reset = 1'b1; l0_full = 1'b0; ofifo_valid = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    run_tile(3, 1, 1'b0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
